// File: rtl/ff_bank_pkg.sv
// Shared constants for the multi-mode flip-flop bank.
//   MODE_*  : encoding of the 2-bit mode input (SR, JK, D, T).
//   POL_*   : SR-mode action taken when S=R=1 (hold, clear, set, toggle).
package ff_bank_pkg;

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam int POL_HOLD = 0;
    localparam int POL_CLR  = 1;
    localparam int POL_SET  = 2;
    localparam int POL_TGL  = 3;

endpackage

// File: rtl/ff_cell.sv
// One-bit combinational next-state logic for the multi-mode bank.
// Ports:
//   mode    : 00 SR, 01 JK, 10 D, 11 T
//   a, b    : S/J/D/T and R/K inputs (b unused in D and T)
//   q       : current registered state of this bit
//   q_next  : state this bit takes if the update is enabled
//   ill     : 1 when SR mode sees S=R=1
module ff_cell
    import ff_bank_pkg::*;
#(
    parameter int ILLEGAL_POLICY = POL_HOLD
) (
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    input  logic       q,
    output logic       q_next,
    output logic       ill
);

    // Resolved once per instance so the S=R=1 path is a constant mux leg.
    logic sr_both;

    always_comb begin
        case (ILLEGAL_POLICY)
            POL_CLR: sr_both = 1'b0;
            POL_SET: sr_both = 1'b1;
            POL_TGL: sr_both = ~q;
            default: sr_both = q;
        endcase
    end

    always_comb begin
        q_next = q;
        ill    = 1'b0;
        case (mode)
            MODE_SR: begin
                case ({a, b})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11: begin
                        q_next = sr_both;
                        ill    = 1'b1;
                    end
                    default: q_next = q;
                endcase
            end
            MODE_JK: begin
                case ({a, b})
                    2'b01:   q_next = 1'b0;
                    2'b10:   q_next = 1'b1;
                    2'b11:   q_next = ~q;
                    default: q_next = q;
                endcase
            end
            MODE_D:  q_next = a;
            default: q_next = q ^ a;
        endcase
    end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit register bank whose bits act as SR, JK, D or T flip-flops,
// selected every cycle by a shared mode input.
// Ports:
//   clk, rst : rising-edge clock, synchronous active-high reset
//   en       : clock enable; 0 freezes q and err_cnt, clears illegal
//   mode     : 00 SR, 01 JK, 10 D, 11 T
//   a, b     : per-bit S/J/D/T and R/K inputs
//   q, qb    : registered state and its combinational complement
//   illegal  : registered per-bit S=R=1 flag, a one-cycle pulse
//   err_cnt  : saturating count of enabled SR cycles with any illegal bit
module multi_mode_ff_bank
    import ff_bank_pkg::*;
#(
    parameter int               WIDTH          = 8,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter int               ILLEGAL_POLICY = POL_HOLD,
    parameter int               CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic [WIDTH-1:0] illegal,
    output logic [CNT_W-1:0] err_cnt
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] illegal_q, illegal_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] cell_next;
    logic [WIDTH-1:0] cell_ill;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell #(
            .ILLEGAL_POLICY(ILLEGAL_POLICY)
        ) u_cell (
            .mode  (mode),
            .a     (a[i]),
            .b     (b[i]),
            .q     (q_q[i]),
            .q_next(cell_next[i]),
            .ill   (cell_ill[i])
        );
    end

    always_comb begin
        q_d       = q_q;
        illegal_d = '0;
        err_cnt_d = err_cnt_q;
        if (en) begin
            q_d       = cell_next;
            illegal_d = cell_ill;
            // Cells only flag in SR mode, so any set bit means an SR event.
            // One increment per cycle regardless of how many bits flagged.
            if (|cell_ill && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= RESET_VAL;
            illegal_q <= '0;
            err_cnt_q <= '0;
        end else begin
            q_q       <= q_d;
            illegal_q <= illegal_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign q       = q_q;
    assign qb      = ~q_q;
    assign illegal = illegal_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed bench: an 8-bit bank (RESET_VAL=A5, hold policy), four 4-bit
// banks sweeping the S=R=1 policy, and a 4-bit bank with a 2-bit counter.
module tb_multi_mode_ff_bank;
    import ff_bank_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- main 8-bit bank ----------------
    logic       rst, en;
    logic [1:0] mode;
    logic [7:0] a, b;
    logic [7:0] q, qb, illegal;
    logic [7:0] err_cnt;

    multi_mode_ff_bank #(
        .WIDTH(8), .RESET_VAL(8'hA5), .ILLEGAL_POLICY(POL_HOLD), .CNT_W(8)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
        .q(q), .qb(qb), .illegal(illegal), .err_cnt(err_cnt)
    );

    // ---------------- small 4-bit banks ----------------
    logic       s_rst, s_en;
    logic [1:0] s_mode;
    logic [3:0] s_a, s_b;
    logic [3:0] pq   [4];
    logic [3:0] pqb  [4];
    logic [3:0] pill [4];
    logic [7:0] pcnt [4];
    logic [3:0] sq, sqb, sill;
    logic [1:0] scnt;

    for (genvar p = 0; p < 4; p++) begin : g_pol
        multi_mode_ff_bank #(
            .WIDTH(4), .RESET_VAL(4'h0), .ILLEGAL_POLICY(p), .CNT_W(8)
        ) u_pol (
            .clk(clk), .rst(s_rst), .en(s_en), .mode(s_mode), .a(s_a), .b(s_b),
            .q(pq[p]), .qb(pqb[p]), .illegal(pill[p]), .err_cnt(pcnt[p])
        );
    end

    multi_mode_ff_bank #(
        .WIDTH(4), .RESET_VAL(4'h0), .ILLEGAL_POLICY(POL_HOLD), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst(s_rst), .en(s_en), .mode(s_mode), .a(s_a), .b(s_b),
        .q(sq), .qb(sqb), .illegal(sill), .err_cnt(scnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, input logic e, input logic [1:0] m,
                       input logic [7:0] va, input logic [7:0] vb);
        rst = r; en = e; mode = m; a = va; b = vb;
        step();
    endtask

    task automatic sdrv(input logic r, input logic e, input logic [1:0] m,
                        input logic [3:0] va, input logic [3:0] vb);
        s_rst = r; s_en = e; s_mode = m; s_a = va; s_b = vb;
        step();
    endtask

    localparam logic [3:0] POL_FROM0 = 4'b1100; // bit p = expected q for policy p
    localparam logic [3:0] POL_FROM1 = 4'b0101;

    initial begin
        logic [3:0] exp0, exp1;
        logic [1:0] sat_exp [5];
        exp0 = POL_FROM0;
        exp1 = POL_FROM1;
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

        rst = 1'b1; en = 1'b1; mode = MODE_D; a = 8'hFF; b = 8'h00;
        s_rst = 1'b1; s_en = 1'b1; s_mode = MODE_D; s_a = 4'hF; s_b = 4'h0;
        #1;

        // Reset held two cycles against a D load of FF
        drv(1'b1, 1'b1, MODE_D, 8'hFF, 8'h00);
        drv(1'b1, 1'b1, MODE_D, 8'hFF, 8'h00);
        chk("rst_q",   q,       8'hA5);
        chk("rst_qb",  qb,      8'h5A);
        chk("rst_ill", illegal, 8'h00);
        chk("rst_cnt", err_cnt, 8'h00);

        // D load and enable freeze
        drv(1'b0, 1'b1, MODE_D, 8'h3C, 8'hFF);
        chk("d_q", q, 8'h3C);
        drv(1'b0, 1'b0, MODE_D, 8'hC3, 8'h00);
        chk("en0_q",   q,       8'h3C);
        chk("en0_ill", illegal, 8'h00);

        // SR with hold policy from 0F
        drv(1'b0, 1'b1, MODE_D, 8'h0F, 8'h00);
        chk("load0f", q, 8'h0F);
        drv(1'b0, 1'b1, MODE_SR, 8'hF3, 8'h33);
        chk("sr_q",   q,       8'hCF);
        chk("sr_ill", illegal, 8'h33);
        chk("sr_cnt", err_cnt, 8'd1);
        for (int i = 0; i < 3; i++) drv(1'b0, 1'b1, MODE_SR, 8'hF3, 8'h33);
        chk("sr_q4",   q,       8'hCF);
        chk("sr_cnt4", err_cnt, 8'd4);

        // Disabled SR cycle with S=R=1: nothing flags, nothing counts
        drv(1'b0, 1'b0, MODE_SR, 8'hFF, 8'hFF);
        chk("en0_sr_ill", illegal, 8'h00);
        chk("en0_sr_cnt", err_cnt, 8'd4);
        chk("en0_sr_q",   q,       8'hCF);

        // JK toggle then T
        drv(1'b0, 1'b1, MODE_D, 8'h55, 8'h00);
        drv(1'b0, 1'b1, MODE_JK, 8'hFF, 8'hFF);
        chk("jk_q",   q,       8'hAA);
        chk("jk_ill", illegal, 8'h00);
        chk("jk_cnt", err_cnt, 8'd4);
        drv(1'b0, 1'b1, MODE_T, 8'h0F, 8'hFF);
        chk("t_q",  q,  8'hA5);
        chk("t_qb", qb, 8'h5A);

        // JK set/clear/hold mix: q=A5, a=0C (set), b=30 (clear) -> 8D... bits:
        // set bits 3,2 -> A5|0C=AD; clear bits 5,4 -> AD&CF=8D
        drv(1'b0, 1'b1, MODE_JK, 8'h0C, 8'h30);
        chk("jk_mix", q, 8'h8D);

        // Reset mid-operation discards an illegal SR update
        drv(1'b1, 1'b1, MODE_SR, 8'hFF, 8'hFF);
        chk("midrst_q",   q,       8'hA5);
        chk("midrst_ill", illegal, 8'h00);
        chk("midrst_cnt", err_cnt, 8'd0);

        // Policy sweep on bit 0
        sdrv(1'b0, 1'b1, MODE_D, 4'h0, 4'h0);
        sdrv(1'b0, 1'b1, MODE_SR, 4'h1, 4'h1);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("pol%0d_from0", p), {31'd0, pq[p][0]}, {31'd0, exp0[p]});
            chk($sformatf("pol%0d_ill", p), {28'd0, pill[p]}, 32'h1);
        end
        sdrv(1'b0, 1'b1, MODE_D, 4'h1, 4'h0);
        sdrv(1'b0, 1'b1, MODE_SR, 4'h1, 4'h1);
        for (int p = 0; p < 4; p++)
            chk($sformatf("pol%0d_from1", p), {31'd0, pq[p][0]}, {31'd0, exp1[p]});

        // Saturating 2-bit counter
        sdrv(1'b1, 1'b1, MODE_D, 4'h0, 4'h0);
        chk("sat_rst", {30'd0, scnt}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            sdrv(1'b0, 1'b1, MODE_SR, 4'h3, 4'h3);
            chk($sformatf("sat_%0d", i), {30'd0, scnt}, {30'd0, sat_exp[i]});
        end
        sdrv(1'b1, 1'b1, MODE_SR, 4'h3, 4'h3);
        chk("sat_midrst", {30'd0, scnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
